// File: rtl/d_latch_pkg.sv
// Shared types and helpers for the clocked D-latch model.
package d_latch_pkg;

  typedef enum logic [1:0] {
    L_RESET,
    L_TRANSPARENT,
    L_HOLD
  } latch_mode_e;

  localparam logic DEFAULT_RST_VAL = '0;

  function automatic latch_mode_e latch_mode(input logic rst, input logic c);
    latch_mode_e m;
    if (rst)    m = L_RESET;
    else if (c) m = L_TRANSPARENT;
    else        m = L_HOLD;
    return m;
  endfunction

  function automatic logic next_hold(input logic rst, input logic c, input logic d,
                                     input logic hold, input logic rst_val);
    logic n;
    unique case (latch_mode(rst, c))
      L_RESET:       n = rst_val;
      L_TRANSPARENT: n = d;
      default:       n = hold;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/d_latch_bit.sv
// One latch bit: a hold flop that tracks D while the gate is open, plus the output mux
// that gives zero-latency transparency.
module d_latch_bit
  import d_latch_pkg::*;
#(
  parameter logic RST_VAL = DEFAULT_RST_VAL
) (
  input  logic clk,
  input  logic rst,
  input  logic c,
  input  logic d,
  output logic q,
  output logic hold
);

  latch_mode_e mode;

  assign mode = latch_mode(rst, c);

  always_ff @(posedge clk) begin
    if (rst) hold <= RST_VAL;
    else     hold <= next_hold(1'b0, c, d, hold, RST_VAL);
  end

  // Reset wins over the gate on the output even before the flop is cleared.
  always_comb begin
    q = hold;
    unique case (mode)
      L_RESET:       q = RST_VAL;
      L_TRANSPARENT: q = d;
      default:       q = hold;
    endcase
  end

endmodule

// File: rtl/d_latch_sync.sv
// WIDTH-bit gated D latch built from clocked hold registers; D_LATCH_STATUS_EN adds the
// transparent/chg status outputs.
module d_latch_sync
  import d_latch_pkg::*;
#(
  parameter int                 WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{DEFAULT_RST_VAL}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
`ifdef D_LATCH_STATUS_EN
  output logic [WIDTH-1:0] Qbar,
  output logic             transparent,
  output logic             chg
`else
  output logic [WIDTH-1:0] Qbar
`endif
);

  logic [WIDTH-1:0] hold;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_latch_bit #(
      .RST_VAL(RST_VAL[i])
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .c   (C),
      .d   (D[i]),
      .q   (Q[i]),
      .hold(hold[i])
    );
  end

  assign Qbar = ~Q;

`ifdef D_LATCH_STATUS_EN
  logic chg_q;
  logic hold_changing;

  // The flops load D only while open, so a change is exactly an open cycle with D != hold.
  assign hold_changing = C & ~rst & (D != hold);
  assign transparent   = C & ~rst;

  always_ff @(posedge clk) begin
    if (rst) chg_q <= 1'b0;
    else     chg_q <= hold_changing;
  end

  assign chg = chg_q & ~rst;
`else
  logic unused_hold;
  assign unused_hold = ^hold;
`endif

endmodule

// File: tb/tb_d_latch_sync.sv
// Directed bench for d_latch_sync: a 1-bit instance and an 8-bit instance with RST_VAL=A5.
module tb_d_latch_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       c1, c8;
  logic [0:0] d1, q1, qb1;
  logic [7:0] d8, q8, qb8;
`ifdef D_LATCH_STATUS_EN
  logic       tr1, chg1, tr8, chg8;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  d_latch_sync #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .C(c1), .D(d1), .Q(q1),
`ifdef D_LATCH_STATUS_EN
    .Qbar(qb1), .transparent(tr1), .chg(chg1)
`else
    .Qbar(qb1)
`endif
  );

  d_latch_sync #(.WIDTH(8), .RST_VAL(8'hA5)) u_w8 (
    .clk(clk), .rst(rst), .C(c8), .D(d8), .Q(q8),
`ifdef D_LATCH_STATUS_EN
    .Qbar(qb8), .transparent(tr8), .chg(chg8)
`else
    .Qbar(qb8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; c1 = 1'b0; d1 = 1'b0; c8 = 1'b0; d8 = 8'h00;
    nxt(); nxt(); #2;
    chk("rst_q1",  q1,  1'b0);
    chk("rst_qb1", qb1, 1'b1);
    chk("rst_q8",  q8,  8'hA5);
    chk("rst_qb8", qb8, 8'h5A);
`ifdef D_LATCH_STATUS_EN
    chk("rst_chg8", chg8, 1'b0);
    chk("rst_tr8",  tr8,  1'b0);
`endif

    // release with gates closed: reset value persists
    nxt(); rst = 1'b0; #2;
    chk("rel_q1",  q1,  1'b0);
    chk("rel_qb1", qb1, 1'b1);
    chk("rel_q8",  q8,  8'hA5);

    // 8-bit: open one cycle with 3C, then close with D moving
    nxt(); c8 = 1'b1; d8 = 8'h3C; #2;
    chk("open_q8",  q8,  8'h3C);
    chk("open_qb8", qb8, 8'hC3);
`ifdef D_LATCH_STATUS_EN
    chk("open_tr8",  tr8,  1'b1);
    chk("open_chg8", chg8, 1'b0);
`endif
    nxt(); c8 = 1'b0; d8 = 8'hFF; #2;
    chk("close_q8", q8, 8'h3C);
`ifdef D_LATCH_STATUS_EN
    chk("close_chg8", chg8, 1'b1);
    chk("close_tr8",  tr8,  1'b0);
`endif
    nxt(); #2;
    chk("held_q8", q8, 8'h3C);
`ifdef D_LATCH_STATUS_EN
    chk("held_chg8", chg8, 1'b0);
`endif

    // 1-bit: D moves while closed for 5 cycles
    d1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nxt(); #2;
      chk("opaque_q1",  q1,  1'b0);
      chk("opaque_qb1", qb1, 1'b1);
    end

    // opening gives zero-latency follow
    nxt(); c1 = 1'b1; #2;
    chk("follow1_q1", q1, 1'b1);
    d1 = 1'b0; #2;
    chk("follow0_q1", q1, 1'b0);
    d1 = 1'b1; #2;
    chk("follow1b_q1", q1, 1'b1);

    // close while D falls in the same cycle
    nxt(); c1 = 1'b0; d1 = 1'b0; #2;
    chk("close_q1",  q1,  1'b1);
    chk("close_qb1", qb1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      nxt(); #2;
      chk("hold_q1",  q1,  1'b1);
      chk("hold_qb1", qb1, 1'b0);
    end

    // reset overrides an open gate
    nxt(); c1 = 1'b1; d1 = 1'b1; rst = 1'b1; #2;
    chk("rstc_q1",  q1,  1'b0);
    chk("rstc_qb1", qb1, 1'b1);
    chk("rstc_q8",  q8,  8'hA5);
    nxt(); rst = 1'b0; c1 = 1'b0; #2;
    chk("rstrel_q1", q1, 1'b0);
    nxt(); #2;
    chk("rstrel2_q1", q1, 1'b0);
    nxt(); c1 = 1'b1; #2;
    chk("reopen_q1", q1, 1'b1);

    // C toggling: each open cycle captures its own D
    nxt(); d1 = 1'b0; #2;
    chk("tog_open0_q1", q1, 1'b0);
    nxt(); c1 = 1'b0; d1 = 1'b1; #2;
    chk("tog_hold0_q1", q1, 1'b0);
    nxt(); c1 = 1'b1; d1 = 1'b1; #2;
    chk("tog_open1_q1", q1, 1'b1);
    nxt(); c1 = 1'b0; d1 = 1'b0; #2;
    chk("tog_hold1_q1",  q1,  1'b1);
    chk("tog_hold1_qb1", qb1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
